// File: rtl/al422_frame_writer_pkg.sv
// Shared types for the AL422 frame writer: FSM states and output byte layout.
// Byte bits 2:0 carry the upper-half pixel (rgb1); bits 5:3 carry the lower half (rgb2).
package al422_frame_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRST,
        ST_FILL,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam int BIT_R1 = 0;
    localparam int BIT_G1 = 1;
    localparam int BIT_B1 = 2;
    localparam int BIT_R2 = 3;
    localparam int BIT_G2 = 4;
    localparam int BIT_B2 = 5;
    localparam int PAD_W  = 2;

    function automatic logic [7:0] pack_byte(
        input logic ru, input logic gu, input logic bu,
        input logic rl, input logic gl, input logic bl
    );
        logic [7:0] b;
        b         = '0;
        b[BIT_R1] = ru;
        b[BIT_G1] = gu;
        b[BIT_B1] = bu;
        b[BIT_R2] = rl;
        b[BIT_G2] = gl;
        b[BIT_B2] = bl;
        return b;
    endfunction

endpackage

// File: rtl/al422_frame_writer_line_buf.sv
// One row pair of pixels: simple dual-port RAM, synchronous write, registered read.
// Read latency 1 cycle; no flow control (addresses are always accepted).
module al422_frame_writer_line_buf #(
    parameter int  COLS = 64,
    parameter int  DW   = 48,
    localparam int AW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          in_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [COLS];

    always_ff @(posedge in_clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_dat;
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/al422_frame_writer.sv
// Buffers one row pair of raster pixels and writes it to the AL422 as BITS bitplanes, LSB plane first.
// Byte latency: first WE-low one cycle after EMIT entry; pix_ready is low outside FILL (source holds data).
module al422_frame_writer
    import al422_frame_writer_pkg::*;
#(
    parameter int COLS        = 64,
    parameter int ROWS        = 16,
    parameter int BITS        = 8,
    parameter int WRST_CYCLES = 4
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              frame_start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [3*BITS-1:0] pix_upper,
    input  logic [3*BITS-1:0] pix_lower,
    output logic              al422_wrst_n,
    output logic              al422_we_n,
    output logic [7:0]        al422_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int PIXW = 3 * BITS;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW   = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WW   = $clog2(WRST_CYCLES + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(BITS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [WW-1:0] WRST_LAST  = WW'(WRST_CYCLES - 1);

    state_t          state;
    logic [CW-1:0]   col;
    logic [PW-1:0]   plane;
    logic [RW-1:0]   row;
    logic [WW-1:0]   wcnt;

    logic            wr_en;
    logic [CW-1:0]   rd_addr;
    logic [2*PIXW-1:0] rd_dat;
    logic [7:0]      slice_byte;

    assign wr_en = (state == ST_FILL) && pix_valid && pix_ready;

    // Read one column ahead so the RAM latency never gaps the WE-low run;
    // outside EMIT column 0 is pre-read, ready for the first EMIT cycle.
    always_comb begin
        rd_addr = '0;
        if (state == ST_EMIT && col != COL_LAST)
            rd_addr = col + CW'(1);
    end

    al422_frame_writer_line_buf #(
        .COLS (COLS),
        .DW   (2 * PIXW)
    ) u_line_buf (
        .in_clk  (in_clk),
        .wr_en   (wr_en),
        .wr_addr (col),
        .wr_dat  ({pix_lower, pix_upper}),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        logic [PIXW-1:0] up;
        logic [PIXW-1:0] lo;
        int              p;
        up = rd_dat[PIXW-1:0];
        lo = rd_dat[2*PIXW-1:PIXW];
        p  = int'(plane);
        slice_byte = pack_byte(up[p], up[BITS + p], up[2*BITS + p],
                               lo[p], lo[BITS + p], lo[2*BITS + p]);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state        <= ST_IDLE;
            col          <= '0;
            plane        <= '0;
            row          <= '0;
            wcnt         <= '0;
            pix_ready    <= 1'b0;
            al422_wrst_n <= 1'b1;
            al422_we_n   <= 1'b1;
            al422_data   <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            al422_we_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state        <= ST_WRST;
                        busy         <= 1'b1;
                        al422_wrst_n <= 1'b0;
                        wcnt         <= '0;
                        col          <= '0;
                        plane        <= '0;
                        row          <= '0;
                    end
                end
                ST_WRST: begin
                    if (wcnt == WRST_LAST) begin
                        al422_wrst_n <= 1'b1;
                        pix_ready    <= 1'b1;
                        state        <= ST_FILL;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                ST_FILL: begin
                    if (wr_en) begin
                        if (col == COL_LAST) begin
                            col       <= '0;
                            plane     <= '0;
                            pix_ready <= 1'b0;
                            state     <= ST_EMIT;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    al422_we_n <= 1'b0;
                    al422_data <= slice_byte;
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (plane == PLANE_LAST) begin
                            plane <= '0;
                            if (row == ROW_LAST) begin
                                row        <= '0;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                state      <= ST_DONE;
                            end else begin
                                row       <= row + RW'(1);
                                pix_ready <= 1'b1;
                                state     <= ST_FILL;
                            end
                        end else begin
                            plane <= plane + PW'(1);
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_al422_frame_writer.sv
// Scoreboard bench: expected FIFO bytes queued per accepted row pair, checked as WE-low bytes appear.
module tb_al422_frame_writer;

    localparam int COLS = 64;
    localparam int ROWS = 16;
    localparam int BITS = 8;
    localparam int NB   = ROWS * BITS * COLS;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        frame_start;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_upper;
    logic [23:0] pix_lower;
    logic        al422_wrst_n;
    logic        al422_we_n;
    logic [7:0]  al422_data;
    logic        busy;
    logic        frame_done;

    always #5 in_clk = ~in_clk;

    al422_frame_writer #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .BITS        (BITS),
        .WRST_CYCLES (4)
    ) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_upper    (pix_upper),
        .pix_lower    (pix_lower),
        .al422_wrst_n (al422_wrst_n),
        .al422_we_n   (al422_we_n),
        .al422_data   (al422_data),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    int          errors = 0;
    int          checks = 0;
    logic [23:0] img_u [ROWS][COLS];
    logic [23:0] img_l [ROWS][COLS];
    logic [7:0]  fifo_mem [NB];
    logic [7:0]  ref_mem [NB];
    logic [7:0]  exp_q [$];
    int          wptr = 0;
    int          we_total = 0;
    int          done_total = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [23:0] u, input logic [23:0] l, input int p);
        return {2'b00, l[16+p], l[8+p], l[p], u[16+p], u[8+p], u[p]};
    endfunction

    task automatic clear_img();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                img_u[r][c] = '0;
                img_l[r][c] = '0;
            end
    endtask

    task automatic random_img();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                img_u[r][c] = 24'($urandom);
                img_l[r][c] = 24'($urandom);
            end
    endtask

    task automatic start_frame();
        int lowcnt;
        bit seen;
        lowcnt = 0;
        seen   = 1'b0;
        frame_start = 1'b1;
        @(posedge in_clk); #1;
        frame_start = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge in_clk);
            if (!al422_wrst_n) lowcnt++;
            if (pix_ready) seen = 1'b1;
        end
        chk("wrst_low_cycles", lowcnt, 4);
        chk("pix_ready_after_wrst", pix_ready, 1);
        chk("busy_in_frame", busy, 1);
    endtask

    task automatic feed_rows(input int nrows, input bit rnd);
        bit pv;
        bit acc;
        int guard;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < COLS; c++) begin
                guard = 0;
                do begin
                    pv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    pix_valid = pv;
                    pix_upper = pv ? img_u[r][c] : 24'($urandom);
                    pix_lower = pv ? img_l[r][c] : 24'($urandom);
                    acc = pv && pix_ready;
                    @(posedge in_clk); #1;
                    guard++;
                end while (!acc && guard < 3000);
                if (!acc) begin
                    chk("accept_timeout", 0, 1);
                    pix_valid = 1'b0;
                    return;
                end
            end
            pix_valid = 1'b0;
            for (int p = 0; p < BITS; p++)
                for (int c = 0; c < COLS; c++)
                    exp_q.push_back(exp_byte(img_u[r][c], img_l[r][c], p));
        end
    endtask

    task automatic run_frame(input bit rnd, input string name);
        int  we0;
        int  d0;
        bit  seen;
        we0  = we_total;
        d0   = done_total;
        seen = 1'b0;
        start_frame();
        feed_rows(ROWS, rnd);
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge in_clk);
            if (frame_done) seen = 1'b1;
        end
        repeat (4) @(negedge in_clk);
        chk({name, "_we_low_cycles"}, we_total - we0, NB);
        chk({name, "_done_pulses"}, done_total - d0, 1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_busy_clear"}, busy, 0);
    endtask

    function automatic int nonzero_bytes();
        int n = 0;
        for (int i = 0; i < NB; i++)
            if (fifo_mem[i] != 8'h00) n++;
        return n;
    endfunction

    // Read the FIFO image back the way the BAM reader does: rgb1/rgb2 per row, plane, column.
    function automatic int bam_mismatches();
        int n = 0;
        logic [7:0] b;
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < BITS; p++)
                for (int c = 0; c < COLS; c++) begin
                    b = fifo_mem[(r * BITS + p) * COLS + c];
                    if (b[2:0] !== {img_u[r][c][16+p], img_u[r][c][8+p], img_u[r][c][p]}) n++;
                    if (b[5:3] !== {img_l[r][c][16+p], img_l[r][c][8+p], img_l[r][c][p]}) n++;
                    if (b[7:6] !== 2'b00) n++;
                end
        return n;
    endfunction

    initial begin
        int diffs;
        in_rst      = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_upper   = '0;
        pix_lower   = '0;
        for (int i = 0; i < NB; i++) fifo_mem[i] = '0;

        fork
            forever begin
                logic [7:0] e;
                @(negedge in_clk);
                if (frame_done) done_total++;
                if (!al422_wrst_n) begin
                    wptr = 0;
                end else if (!al422_we_n) begin
                    we_total++;
                    if (wptr < NB) fifo_mem[wptr] = al422_data;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'h0, al422_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("byte%0d", wptr), al422_data, e);
                    end
                    wptr++;
                end
            end
        join_none

        repeat (3) @(posedge in_clk);
        #1 in_rst = 1'b0;
        @(negedge in_clk);
        chk("rst_we_n", al422_we_n, 1);
        chk("rst_wrst_n", al422_wrst_n, 1);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_data", al422_data, 0);
        repeat (100) @(negedge in_clk);
        chk("idle_we_n", al422_we_n, 1);
        chk("idle_wrst_n", al422_wrst_n, 1);
        chk("idle_pix_ready", pix_ready, 0);
        chk("idle_busy", busy, 0);

        clear_img();
        img_u[0][0] = 24'h000001;
        run_frame(1'b0, "single_r");
        chk("single_r_byte0", fifo_mem[0], 8'h01);
        chk("single_r_nonzero", nonzero_bytes(), 1);

        clear_img();
        img_l[0][3] = 24'h008000;
        run_frame(1'b0, "lower_g");
        chk("lower_g_byte451", fifo_mem[451], 8'h10);
        chk("lower_g_nonzero", nonzero_bytes(), 1);

        random_img();
        run_frame(1'b0, "rand_full");
        for (int i = 0; i < NB; i++) ref_mem[i] = fifo_mem[i];
        run_frame(1'b1, "rand_gappy");
        diffs = 0;
        for (int i = 0; i < NB; i++)
            if (fifo_mem[i] !== ref_mem[i]) diffs++;
        chk("gappy_vs_full_stream", diffs, 0);
        chk("gappy_bam_decode", bam_mismatches(), 0);

        random_img();
        start_frame();
        feed_rows(6, 1'b0);
        repeat (100) @(posedge in_clk);
        #1 in_rst = 1'b1;
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        @(negedge in_clk);
        chk("abort_we_n", al422_we_n, 1);
        chk("abort_busy", busy, 0);
        chk("abort_pix_ready", pix_ready, 0);
        chk("abort_wrst_n", al422_wrst_n, 1);
        exp_q.delete();
        for (int i = 0; i < NB; i++) fifo_mem[i] = 8'hEE;
        random_img();
        run_frame(1'b1, "after_abort");
        chk("after_abort_bam_decode", bam_mismatches(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
